// File: rtl/sprite_dma_pkg.sv
// Shared types and constants for the sprite attribute RAM DMA sequencer.
//   state_t       : sequencer states (IDLE, RD, WR, CPU, DONE)
//   END_MARKER    : byte value that terminates a sprite list when found in byte 0 of an entry
//   byte_field_w  : width of the byte-within-entry field of a RAM address
package sprite_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_CPU,
    ST_DONE
  } state_t;

  localparam logic [7:0] END_MARKER = 8'hFF;

  // BYTES_PER_SPRITE is a power of two, so the low log2 bits of an address
  // select the byte inside an entry. A value of 1 gives a zero-width field.
  function automatic int byte_field_w(input int bytes_per_sprite);
    return $clog2(bytes_per_sprite);
  endfunction

endpackage

// File: rtl/sprite_dma_ctrl.sv
// Sprite attribute RAM sequencer / arbiter.
// On a dmaon_n request, copies the sprite list from the single-port sprite RAM
// into the line-buffer work RAM one byte per two cycles (RD, WR), stopping at
// the end of the list or at an END_MARKER in byte 0 of an entry, then pulses
// dmaend. The Z80 owns the sprite RAM port whenever no transfer is running and
// is held off with cpu_wait while a transfer owns it.
//
// Optional feature: define SPRITE_DMA_CPU_STEAL_EN to let a pending CPU access
// steal one cycle (CPU state) after each non-final WR.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   dmaon_n                          transfer request, level, active low
//   dmaend, busy                     end-of-list pulse, transfer in progress
//   cpu_req/we/addr/wdata, cpu_rdata CPU access port (rdata valid cycle after grant)
//   cpu_wait                         CPU stall while request is not granted
//   ram_addr/we/wdata, ram_rdata     sprite RAM port (1-cycle synchronous read)
//   buf_addr/we/wdata                work RAM write port
module sprite_dma_ctrl
  import sprite_dma_pkg::*;
#(
  parameter int NUM_SPRITES      = 32,
  parameter int BYTES_PER_SPRITE = 16,
  parameter int ADDR_W           = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmaon_n,
  output logic              dmaend,
  output logic              busy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_we,
  output logic [7:0]        buf_wdata
);

  localparam int                FIELD_W    = byte_field_w(BYTES_PER_SPRITE);
  localparam logic [ADDR_W-1:0] FIELD_MASK = ADDR_W'((1 << FIELD_W) - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_SPRITES * BYTES_PER_SPRITE - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              armed, armed_nxt;
  logic              grant;        // CPU owns the RAM port this cycle
  logic              rd_pend;      // a CPU read was granted last cycle
  logic [7:0]        rdata_q;
  logic              is_marker;

  assign is_marker = ((cnt & FIELD_MASK) == '0) && (ram_rdata == END_MARKER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      armed   <= 1'b1;
      rd_pend <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      rd_pend <= grant & ~cpu_we;
      if (rd_pend) rdata_q <= ram_rdata;
    end
  end

  // Read data appears straight from the RAM in the cycle after the grant and
  // is then held, so DMA reads that follow do not disturb what the CPU sees.
  assign cpu_rdata = rd_pend ? ram_rdata : rdata_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    // A high sample of dmaon_n re-arms; a level held low never retriggers.
    armed_nxt = armed | dmaon_n;
    grant     = 1'b0;
    busy      = 1'b0;
    dmaend    = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    buf_addr  = '0;
    buf_we    = 1'b0;
    buf_wdata = 8'h00;

    case (state)
      ST_IDLE: begin
        grant     = cpu_req;
        ram_addr  = cpu_addr;
        ram_we    = cpu_we & cpu_req;
        ram_wdata = cpu_wdata;
        if (armed && !dmaon_n) begin
          cnt_nxt   = '0;
          armed_nxt = 1'b0;
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        busy      = 1'b1;
        ram_addr  = cnt;
        state_nxt = dmaon_n ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        busy      = 1'b1;
        buf_addr  = cnt;
        buf_wdata = ram_rdata;
        buf_we    = ~is_marker;
        if (dmaon_n) begin
          state_nxt = ST_IDLE;
        end else if (is_marker || cnt == LAST_ADDR) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
`ifdef SPRITE_DMA_CPU_STEAL_EN
          state_nxt = cpu_req ? ST_CPU : ST_RD;
`else
          state_nxt = ST_RD;
`endif
        end
      end
      ST_CPU: begin
        busy      = 1'b1;
        grant     = cpu_req;
        ram_addr  = cpu_addr;
        ram_we    = cpu_we & cpu_req;
        ram_wdata = cpu_wdata;
        state_nxt = dmaon_n ? ST_IDLE : ST_RD;
      end
      ST_DONE: begin
        dmaend    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    cpu_wait = cpu_req & ~grant;
  end

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// Bench for sprite_dma_ctrl: sprite RAM and work RAM models, a phase-level
// reference model, a per-cycle output compare, directed scenarios and a
// randomized CPU-traffic phase.
module tb_sprite_dma_ctrl;
  localparam int NUM_SPRITES = 32;
  localparam int BPS         = 16;
  localparam int ADDR_W      = 9;
  localparam int NB          = NUM_SPRITES * BPS;
`ifdef SPRITE_DMA_CPU_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, dmaon_n = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = 8'h00;
  logic dmaend, busy, cpu_wait, ram_we, buf_we;
  logic [7:0] cpu_rdata, ram_wdata, buf_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [ADDR_W-1:0] ram_addr, buf_addr;

  always #5 clk = ~clk;

  sprite_dma_ctrl #(.NUM_SPRITES(NUM_SPRITES), .BYTES_PER_SPRITE(BPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .dmaon_n(dmaon_n), .dmaend(dmaend), .busy(busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata)
  );

  // Environment memories; load_pulse reloads sprite RAM and poisons work RAM.
  logic [7:0] spr_mem [NB];
  logic [7:0] buf_mem [NB];
  logic [7:0] init_mem [NB];
  logic load_pulse = 1'b0;

  always @(posedge clk) begin
    if (load_pulse) begin
      for (int i = 0; i < NB; i++) begin
        spr_mem[i] <= init_mem[i];
        buf_mem[i] <= 8'hA5;
      end
    end else begin
      if (ram_we) spr_mem[ram_addr] <= ram_wdata;
      if (buf_we) buf_mem[buf_addr] <= buf_wdata;
    end
    ram_rdata <= spr_mem[ram_addr];
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: where the copy is (phase, byte index), whether a request
  // may start one, what the sprite RAM holds and what the CPU last read.
  localparam int P_IDLE = 0, P_READ = 1, P_WRITE = 2, P_STEAL = 3, P_DONE = 4;
  int m_ph = P_IDLE, m_idx = 0;
  bit m_armed = 1'b1;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] ref_spr [NB];

  function automatic bit marker_at(input int idx, input logic [7:0] v);
    return (idx % BPS == 0) && (v == 8'hFF);
  endfunction

  always @(posedge clk) begin : model
    int ph, idx;
    bit arm, cpu_owns;
    ph = m_ph; idx = m_idx; arm = m_armed | dmaon_n;
    cpu_owns = (m_ph == P_IDLE) || (m_ph == P_STEAL);
    if (load_pulse) begin
      for (int i = 0; i < NB; i++) ref_spr[i] <= init_mem[i];
    end else if (cpu_owns && cpu_req && cpu_we) begin
      ref_spr[cpu_addr] <= cpu_wdata;
    end
    if (rst) m_rdata <= 8'h00;
    else if (cpu_owns && cpu_req && !cpu_we) m_rdata <= ref_spr[cpu_addr];
    if (rst) begin
      ph = P_IDLE; arm = 1'b1;
    end else if (m_ph == P_IDLE) begin
      if (m_armed && !dmaon_n) begin ph = P_READ; idx = 0; arm = 1'b0; end
    end else if (m_ph == P_DONE) begin
      ph = P_IDLE;
    end else if (dmaon_n) begin
      ph = P_IDLE;                                    // abort
    end else if (m_ph == P_WRITE) begin
      if (marker_at(m_idx, ref_spr[m_idx]) || m_idx == NB - 1) ph = P_DONE;
      else begin idx = m_idx + 1; ph = (STEAL && cpu_req) ? P_STEAL : P_READ; end
    end else begin
      ph = (m_ph == P_READ) ? P_WRITE : P_READ;
    end
    m_ph <= ph; m_idx <= idx; m_armed <= arm;
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin : compare
    bit own, wr, mk;
    if (chk_en) begin
      own = (m_ph == P_IDLE) || (m_ph == P_STEAL);
      wr  = (m_ph == P_WRITE);
      mk  = wr && marker_at(m_idx, ref_spr[m_idx]);
      chk("busy", 32'(busy), 32'(m_ph == P_READ || m_ph == P_WRITE || m_ph == P_STEAL));
      chk("dmaend", 32'(dmaend), 32'(m_ph == P_DONE));
      chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !own));
      chk("ram_we", 32'(ram_we), 32'(own && cpu_req && cpu_we));
      chk("ram_addr", 32'(ram_addr), own ? 32'(cpu_addr) : (m_ph == P_READ ? 32'(m_idx) : 32'd0));
      chk("ram_wdata", 32'(ram_wdata), own ? 32'(cpu_wdata) : 32'd0);
      chk("buf_we", 32'(buf_we), 32'(wr && !mk));
      chk("buf_addr", 32'(buf_addr), wr ? 32'(m_idx) : 32'd0);
      chk("buf_wdata", 32'(buf_wdata), wr ? 32'(ref_spr[m_idx]) : 32'd0);
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    end
  end

  int cyc = 0, n_end = 0, n_bufw = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dmaend) n_end <= n_end + 1;
    if (buf_we) n_bufw <= n_bufw + 1;
  end

  task automatic wait_end(input int budget, input string nm, output int at);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (dmaend !== 1'b1 && k < budget);
    chk(nm, 32'(dmaend), 32'd1);
    at = cyc;
  endtask

  task automatic wait_buf(input int a, input int budget, input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(buf_we === 1'b1 && int'(buf_addr) == a) && k < budget);
    chk(nm, 32'(buf_we === 1'b1 && int'(buf_addr) == a), 32'd1);
  endtask

  task automatic reload();
    @(negedge clk); #1 load_pulse = 1'b1;
    @(negedge clk); #1 load_pulse = 1'b0;
  endtask

  initial begin
    int t0, t1, e0, b0, waited, nbad, k;
    logic busy_at;
    for (int i = 0; i < NB; i++) begin
      init_mem[i] = 8'($urandom);
      if (i % BPS == 0 && init_mem[i] == 8'hFF) init_mem[i] = 8'h00;
    end
    load_pulse = 1'b1;
    @(posedge clk); #1 load_pulse = 1'b0; chk_en = 1'b1;
    // reset state, inputs idle
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dmaend", 32'(dmaend), 32'd0);
    chk("reset_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_buf_we", 32'(buf_we), 32'd0);
    chk("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
    #1 rst = 1'b0;

    // full list: one byte per RD/WR pair, DONE on cycle 1025
    e0 = n_end;
    @(negedge clk); #1 dmaon_n = 1'b0;
    @(negedge clk);
    chk("start_latency_busy", 32'(busy), 32'd1);
    t0 = cyc;
    wait_end(1100, "full_dmaend", t1);
    chk("full_cycles", 32'(t1 - t0 + 1), 32'd1025);
    #1 dmaon_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("full_one_pulse", 32'(n_end - e0), 32'd1);
    nbad = 0;
    for (int i = 0; i < NB; i++) if (buf_mem[i] !== spr_mem[i]) nbad++;
    chk("full_copy_mismatches", 32'(nbad), 32'd0);

    // end-of-list marker at sprite 3 byte 0
    init_mem[48] = 8'hFF;
    reload();
    e0 = n_end; b0 = n_bufw;
    #1 dmaon_n = 1'b0;
    wait_end(300, "marker_dmaend", t1);
    #1 dmaon_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("marker_bytes", 32'(n_bufw - b0), 32'd48);
    chk("marker_one_pulse", 32'(n_end - e0), 32'd1);
    chk("marker_untouched_030", 32'(buf_mem[48]), 32'hA5);
    chk("marker_copied_02f", 32'(buf_mem[47]), 32'(init_mem[47]));
    init_mem[48] = 8'h12;
    reload();

    // dmaon_n held low: one transfer only; re-arm with a high pulse
    e0 = n_end;
    #1 dmaon_n = 1'b0;
    repeat (3000) @(negedge clk);
    chk("held_low_one_xfer", 32'(n_end - e0), 32'd1);
    #1 dmaon_n = 1'b1;
    @(negedge clk); #1 dmaon_n = 1'b0;
    wait_end(1100, "rearm_dmaend", t1);
    #1 dmaon_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rearm_two_xfers", 32'(n_end - e0), 32'd2);

    // CPU write of 5A to 0x010 in the middle of a transfer
    #1 dmaon_n = 1'b0;
    wait_buf(50, 200, "cpu_mid_reached");
    #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 8'h5A;
    waited = 0;
    @(negedge clk);
    while (cpu_wait === 1'b1 && waited < 2000) begin waited++; @(negedge clk); end
    busy_at = busy;
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
    if (STEAL) begin
      chk("steal_wait_short", 32'(waited <= 2), 32'd1);
      chk("steal_busy_at_grant", 32'(busy_at), 32'd1);
      wait_end(1100, "steal_dmaend", t1);
    end else begin
      chk("nosteal_wait_cycles", 32'(waited), 32'(2 * (NB - 1 - 50) + 1));
      chk("nosteal_idle_at_grant", 32'(busy_at), 32'd0);
      @(negedge clk);
    end
    #1 dmaon_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cpu_write_landed", 32'(spr_mem[16]), 32'h5A);
    #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    @(posedge clk); #1 cpu_req = 1'b0; cpu_addr = '0;
    @(negedge clk);
    chk("cpu_read_next_cycle", 32'(cpu_rdata), 32'h5A);
    repeat (3) @(negedge clk);
    chk("cpu_read_holds", 32'(cpu_rdata), 32'h5A);

    // abort by dmaon_n at byte 100, then restart from 0
    #1 dmaon_n = 1'b0;
    wait_buf(100, 400, "abort_byte100_reached");
    #1 dmaon_n = 1'b1;
    e0 = n_end;
    @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_no_buf_we", 32'(buf_we), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_dmaend", 32'(n_end - e0), 32'd0);
    #1 dmaon_n = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (buf_we !== 1'b1 && k < 10);
    chk("abort_restart_addr0", 32'(buf_addr), 32'd0);

    // rst at byte 200, then restart from 0 and finish
    wait_buf(200, 600, "rst_byte200_reached");
    #1 rst = 1'b1; dmaon_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_no_dmaend", 32'(dmaend), 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_pulse", 32'(n_end - e0), 32'd0);
    #1 dmaon_n = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (buf_we !== 1'b1 && k < 10);
    chk("rst_restart_addr0", 32'(buf_addr), 32'd0);
    wait_end(1100, "rst_restart_dmaend", t1);
    #1 dmaon_n = 1'b1;
    repeat (2) @(negedge clk);

    // random CPU traffic against transfers
    for (int r = 0; r < 2; r++) begin
      e0 = n_end;
      #1 dmaon_n = 1'b0;
      k = 0;
      do begin
        @(negedge clk); #1;
        cpu_req   = ($urandom_range(0, 3) == 0);
        cpu_we    = 1'($urandom);
        cpu_addr  = 9'($urandom);
        cpu_wdata = 8'($urandom);
        k++;
      end while (n_end == e0 && k < 3000);
      cpu_req = 1'b0; cpu_we = 1'b0; dmaon_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rand_dmaend", 32'(n_end - e0), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
